skdecode_t0_ctrl: RTL and testbench

Sequencer for t0 decoding of a packed ML-DSA secret key. It streams NUM_POLY polynomials of 13-bit packed t0 fields out of the 64-bit sk memory and realigns them in a bit buffer. Four fields per cycle go to four internal skdecode_t0_unpack lanes, each computing (2^12 − field) mod q. The block writes four 24-bit coefficients per cycle to the coefficient memory and sits between the sk memory and the NTT/signing datapath.

---
 rtl/skdecode_t0_ctrl.sv | 242 ++++++++++++++++++++++++
 tb/tb_skdecode_t0_ctrl.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/skdecode_t0_ctrl.sv
// rtl/skdecode_t0_ctrl.sv - t0 secret-key unpack sequencer with four subtract lanes

module skdecode_t0_unpack #(
  parameter int MLDSA_D = 13,
  parameter int MLDSA_Q = 8380417
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               zeroize,
  input  logic               en_i,
  input  logic               sub_i,
  input  logic [MLDSA_D-1:0] field_i,
  output logic               valid_o,
  output logic [23:0]        data_o
);

  localparam logic [23:0] HALF = 24'(1 << (MLDSA_D - 1));
  localparam logic [23:0] QV   = 24'(MLDSA_Q);

  logic [23:0] f_ext;
  logic [23:0] res;

  // (2^(d-1) - f) mod q; fields above 2^(d-1) wrap by adding q back
  always_comb begin
    f_ext = 24'(field_i);
    if (!sub_i)
      res = f_ext;
    else if (f_ext <= HALF)
      res = HALF - f_ext;
    else
      res = QV + HALF - f_ext;
  end

  // One-cycle registered result with a valid strobe
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_o <= 1'b0;
      data_o  <= '0;
    end else if (zeroize) begin
      valid_o <= 1'b0;
      data_o  <= '0;
    end else begin
      valid_o <= en_i;
      if (en_i)
        data_o <= res;
    end
  end

endmodule

module skdecode_t0_ctrl #(
  parameter int SK_ADDR_W  = 14,
  parameter int MEM_ADDR_W = 15,
  parameter int NUM_POLY   = 8,
  parameter int MLDSA_D    = 13,
  parameter int MLDSA_Q    = 8380417
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  zeroize,
  input  logic                  start_i,
  input  logic [SK_ADDR_W-1:0]  src_base_i,
  input  logic [MEM_ADDR_W-1:0] dest_base_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  sk_rd_en_o,
  output logic [SK_ADDR_W-1:0]  sk_rd_addr_o,
  input  logic [63:0]           sk_rd_data_i,
  output logic                  mem_wr_en_o,
  output logic [MEM_ADDR_W-1:0] mem_wr_addr_o,
  output logic [95:0]           mem_wr_data_o
);

  // 52 bits feed the four lanes each emission; a poly is 52 whole words
  localparam int EMIT_W   = 4 * MLDSA_D;
  localparam int TOTAL_RD = NUM_POLY * 256 * MLDSA_D / 64;
  localparam int TOTAL_WR = NUM_POLY * 64;
  localparam int RD_CW    = $clog2(TOTAL_RD + 1);
  localparam int WR_CW    = $clog2(TOTAL_WR + 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t                state;
  logic [RD_CW-1:0]      rd_cnt;
  logic [WR_CW-1:0]      emit_cnt;
  logic [SK_ADDR_W-1:0]  src_q;
  logic [MEM_ADDR_W-1:0] dest_q;
  logic [MEM_ADDR_W-1:0] wr_addr;

  logic [127:0] bitbuf;
  logic [7:0]   fill;
  logic         rd_valid;

  logic         start_accept;
  logic         emit;
  logic         issue;
  logic [7:0]   base_fill;
  logic [127:0] shifted;
  logic [127:0] appended;
  logic [9:0]   fill_n1;
  logic [9:0]   fill_n2;
  logic [9:0]   fill_arr;
  logic         emit_n1;
  logic         emit_n2;

  logic [3:0]   lane_valid;
  logic [23:0]  lane_data [4];

  // Emission, buffer realignment and the read-issue projection. A read
  // decided now lands in the buffer two edges later, so the fill is walked
  // forward through the two intervening cycles (each emitting whenever it
  // can) and the read is allowed only if the buffer still fits 128 bits
  // after its 64 bits are appended.
  always_comb begin
    start_accept = (state == IDLE) && start_i;
    emit         = ((state == RUN) || (state == DRAIN)) && (fill >= 8'(EMIT_W));
    base_fill    = emit ? (fill - 8'(EMIT_W)) : fill;
    shifted      = emit ? (bitbuf >> EMIT_W) : bitbuf;
    appended     = shifted | ({64'd0, sk_rd_data_i} << base_fill);

    fill_n1  = 10'(base_fill) + (rd_valid ? 10'd64 : 10'd0);
    emit_n1  = fill_n1 >= 10'(EMIT_W);
    fill_n2  = fill_n1 - (emit_n1 ? 10'(EMIT_W) : 10'd0) + (sk_rd_en_o ? 10'd64 : 10'd0);
    emit_n2  = fill_n2 >= 10'(EMIT_W);
    fill_arr = fill_n2 - (emit_n2 ? 10'(EMIT_W) : 10'd0) + 10'd64;
    issue    = (state == RUN) && (fill_arr <= 10'd128);
  end

  // Run sequencer: state, read address generation and status outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      busy_o       <= 1'b0;
      done_o       <= 1'b0;
      sk_rd_en_o   <= 1'b0;
      sk_rd_addr_o <= '0;
      rd_cnt       <= '0;
      src_q        <= '0;
      dest_q       <= '0;
    end else if (zeroize) begin
      state        <= IDLE;
      busy_o       <= 1'b0;
      done_o       <= 1'b0;
      sk_rd_en_o   <= 1'b0;
      sk_rd_addr_o <= '0;
      rd_cnt       <= '0;
      src_q        <= '0;
      dest_q       <= '0;
    end else begin
      case (state)
        IDLE: begin
          done_o     <= 1'b0;
          sk_rd_en_o <= 1'b0;
          if (start_accept) begin
            state        <= RUN;
            busy_o       <= 1'b1;
            src_q        <= src_base_i;
            dest_q       <= dest_base_i;
            sk_rd_en_o   <= 1'b1;
            sk_rd_addr_o <= src_base_i;
            rd_cnt       <= RD_CW'(1);
          end
        end
        RUN: begin
          if (issue) begin
            sk_rd_en_o   <= 1'b1;
            sk_rd_addr_o <= src_q + SK_ADDR_W'(rd_cnt);
            rd_cnt       <= rd_cnt + RD_CW'(1);
            if (rd_cnt == RD_CW'(TOTAL_RD - 1))
              state <= DRAIN;
          end else begin
            sk_rd_en_o <= 1'b0;
          end
        end
        DRAIN: begin
          sk_rd_en_o <= 1'b0;
          if (emit && (emit_cnt == WR_CW'(TOTAL_WR - 1))) begin
            state  <= DONE;
            done_o <= 1'b1;
          end
        end
        DONE: begin
          state  <= IDLE;
          done_o <= 1'b0;
          busy_o <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Bit buffer, in-flight tracking and write address generation
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bitbuf   <= '0;
      fill     <= '0;
      rd_valid <= 1'b0;
      emit_cnt <= '0;
      wr_addr  <= '0;
    end else if (zeroize || start_accept) begin
      bitbuf   <= '0;
      fill     <= '0;
      rd_valid <= 1'b0;
      emit_cnt <= '0;
      wr_addr  <= '0;
    end else begin
      rd_valid <= sk_rd_en_o;
      if (rd_valid) begin
        bitbuf <= appended;
        fill   <= base_fill + 8'd64;
      end else begin
        bitbuf <= shifted;
        fill   <= base_fill;
      end
      if (emit) begin
        wr_addr  <= dest_q + MEM_ADDR_W'(emit_cnt);
        emit_cnt <= emit_cnt + WR_CW'(1);
      end
    end
  end

  for (genvar i = 0; i < 4; i++) begin : g_lane
    skdecode_t0_unpack #(
      .MLDSA_D (MLDSA_D),
      .MLDSA_Q (MLDSA_Q)
    ) u_lane (
      .clk     (clk),
      .reset_n (reset_n),
      .zeroize (zeroize),
      .en_i    (emit),
      .sub_i   (1'b1),
      .field_i (bitbuf[MLDSA_D*i +: MLDSA_D]),
      .valid_o (lane_valid[i]),
      .data_o  (lane_data[i])
    );
  end

  assign mem_wr_en_o   = &lane_valid;
  assign mem_wr_addr_o = wr_addr;
  assign mem_wr_data_o = {lane_data[3], lane_data[2], lane_data[1], lane_data[0]};

endmodule

// File: tb/tb_skdecode_t0_ctrl.sv
// tb/tb_skdecode_t0_ctrl.sv - scoreboard bench for skdecode_t0_ctrl

module tb_skdecode_t0_ctrl;

  localparam int NP       = 8;
  localparam int TOTAL_RD = NP * 52;
  localparam int TOTAL_WR = NP * 64;
  localparam int Q        = 8380417;
  localparam int DONE_MAX = 4 + TOTAL_WR + 2;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        zeroize = 1'b0;
  logic        start_i = 1'b0;
  logic [13:0] src_base_i = '0;
  logic [14:0] dest_base_i = '0;
  logic        busy_o, done_o, sk_rd_en_o, mem_wr_en_o;
  logic [13:0] sk_rd_addr_o;
  logic [63:0] sk_rd_data_i = '0;
  logic [14:0] mem_wr_addr_o;
  logic [95:0] mem_wr_data_o;

  skdecode_t0_ctrl #(
    .SK_ADDR_W (14), .MEM_ADDR_W (15), .NUM_POLY (NP), .MLDSA_D (13), .MLDSA_Q (Q)
  ) dut (
    .clk (clk), .reset_n (reset_n), .zeroize (zeroize), .start_i (start_i),
    .src_base_i (src_base_i), .dest_base_i (dest_base_i),
    .busy_o (busy_o), .done_o (done_o),
    .sk_rd_en_o (sk_rd_en_o), .sk_rd_addr_o (sk_rd_addr_o), .sk_rd_data_i (sk_rd_data_i),
    .mem_wr_en_o (mem_wr_en_o), .mem_wr_addr_o (mem_wr_addr_o), .mem_wr_data_o (mem_wr_data_o)
  );

  always #5 clk = ~clk;

  logic [63:0]  sk_mem [0:16383];
  logic [110:0] exp_q [$];
  int           n_checks = 0;
  int           n_fail = 0;
  int           rd_count = 0;
  int           wr_count = 0;
  logic [13:0]  cur_src = '0;
  logic [13:0]  exp_rd_addr;
  logic [110:0] exp_wr;
  logic [95:0]  first_wr_data = '0;
  logic [14:0]  first_wr_addr = '0;
  bit           done_seen = 0;
  bit           done_ok = 0;

  // sk memory: data valid the cycle after the read strobe
  always @(posedge clk) begin
    if (sk_rd_en_o)
      sk_rd_data_i <= sk_mem[sk_rd_addr_o];
  end

  // Scoreboard monitor: read order, write contents, fill bound
  always @(negedge clk) begin
    if (reset_n) begin
      if (sk_rd_en_o) begin
        exp_rd_addr = cur_src + 14'(rd_count);
        n_checks++;
        if (sk_rd_addr_o !== exp_rd_addr) begin
          n_fail++;
          $display("FAIL rd_addr #%0d: got %h want %h", rd_count, sk_rd_addr_o, exp_rd_addr);
        end
        rd_count++;
      end
      if (mem_wr_en_o) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_write: got addr %h data %h want no write", mem_wr_addr_o, mem_wr_data_o);
        end else begin
          exp_wr = exp_q.pop_front();
          if ({mem_wr_addr_o, mem_wr_data_o} !== exp_wr) begin
            n_fail++;
            $display("FAIL wr #%0d: got %h/%h want %h/%h", wr_count, mem_wr_addr_o, mem_wr_data_o,
                     exp_wr[110:96], exp_wr[95:0]);
          end
        end
        if (wr_count == 0) begin
          first_wr_data = mem_wr_data_o;
          first_wr_addr = mem_wr_addr_o;
        end
        wr_count++;
      end
      if (done_o) begin
        done_seen = 1;
        done_ok   = mem_wr_en_o && (wr_count == TOTAL_WR);
      end
      if (busy_o) begin
        n_checks++;
        if (dut.fill > 8'd128) begin
          n_fail++;
          $display("FAIL fill_bound: got %0d want <= 128", dut.fill);
        end
      end
    end
  end

  task automatic randomize_mem();
    for (int a = 0; a < 16384; a++) sk_mem[a] = {$urandom, $urandom};
  endtask

  // Golden model: walk the packed bit stream independently of any buffer
  task automatic build_expect(input logic [13:0] src, input logic [14:0] dest);
    logic [127:0] two;
    logic [13:0]  wa;
    logic [12:0]  f;
    logic [95:0]  d;
    int p, w, o, r;
    exp_q.delete();
    for (int e = 0; e < TOTAL_WR; e++) begin
      for (int i = 0; i < 4; i++) begin
        p  = 52 * e + 13 * i;
        w  = p / 64;
        o  = p % 64;
        wa = src + 14'(w);
        two = {sk_mem[wa + 14'd1], sk_mem[wa]};
        f  = 13'(two >> o);
        r  = 4096 - int'(f);
        if (r < 0) r += Q;
        d[24*i +: 24] = 24'(r);
      end
      exp_q.push_back({dest + 15'(e), d});
    end
  endtask

  task automatic start_run(input logic [13:0] src, input logic [14:0] dest);
    build_expect(src, dest);
    cur_src   = src;
    rd_count  = 0;
    wr_count  = 0;
    done_seen = 0;
    done_ok   = 0;
    @(negedge clk);
    src_base_i  = src;
    dest_base_i = dest;
    start_i     = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
  endtask

  task automatic wait_done(output int cyc);
    cyc = 1;
    while (!done_o && cyc < 2000) begin
      @(negedge clk);
      cyc++;
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    int rd0, wr0;
    @(negedge clk);
    n_checks++;
    if ({busy_o, done_o, sk_rd_en_o, sk_rd_addr_o, mem_wr_en_o, mem_wr_addr_o, mem_wr_data_o} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got busy=%b rd=%b wr=%b data=%h want all 0", busy_o, sk_rd_en_o, mem_wr_en_o, mem_wr_data_o);
    end
    reset_n = 1'b1;
    randomize_mem();
    start_run(14'h0200, 15'h0100);
    repeat (40) @(negedge clk);
    reset_n = 1'b0;
    #1;
    n_checks++;
    if ({busy_o, done_o, sk_rd_en_o, sk_rd_addr_o, mem_wr_en_o, mem_wr_addr_o, mem_wr_data_o} !== '0) begin
      n_fail++;
      $display("FAIL midrun_reset_outputs: got busy=%b rd=%b wr=%b want all 0", busy_o, sk_rd_en_o, mem_wr_en_o);
    end
    exp_q.delete();
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    rd0 = rd_count;
    wr0 = wr_count;
    repeat (20) @(negedge clk);
    n_checks++;
    if (rd_count != rd0 || wr_count != wr0 || busy_o !== 1'b0) begin
      n_fail++;
      $display("FAIL post_reset_idle: got reads+%0d writes+%0d busy=%b want 0 0 0", rd_count - rd0, wr_count - wr0, busy_o);
    end
  endtask

  task automatic check_run_end(input string tag, input int cyc);
    n_checks++;
    if (rd_count != TOTAL_RD || wr_count != TOTAL_WR) begin
      n_fail++;
      $display("FAIL %s_counts: got %0d reads %0d writes want %0d %0d", tag, rd_count, wr_count, TOTAL_RD, TOTAL_WR);
    end
    n_checks++;
    if (!done_seen || !done_ok) begin
      n_fail++;
      $display("FAIL %s_done: got seen=%0d on_last_write=%0d want 1 1", tag, done_seen, done_ok);
    end
    n_checks++;
    if (cyc > DONE_MAX) begin
      n_fail++;
      $display("FAIL %s_latency: got %0d cycles want <= %0d", tag, cyc, DONE_MAX);
    end
    n_checks++;
    if (exp_q.size() != 0 || busy_o !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_drain: got %0d pending busy=%b want 0 0", tag, exp_q.size(), busy_o);
    end
  endtask

  task automatic test_values();
    int cyc;
    randomize_mem();
    sk_mem[14'h0100] = {12'($urandom), 13'd8191, 13'd4097, 13'd4096, 13'd0};
    start_run(14'h0100, 15'h0010);
    n_checks++;
    if (busy_o !== 1'b1 || sk_rd_en_o !== 1'b1 || sk_rd_addr_o !== 14'h0100) begin
      n_fail++;
      $display("FAIL first_read: got busy=%b en=%b addr=%h want 1 1 0100", busy_o, sk_rd_en_o, sk_rd_addr_o);
    end
    wait_done(cyc);
    n_checks++;
    if (first_wr_data !== {24'd8376322, 24'd8380416, 24'd0, 24'd4096} || first_wr_addr !== 15'h0010) begin
      n_fail++;
      $display("FAIL first_write: got %h @%h want %h @0010", first_wr_data, first_wr_addr,
               {24'd8376322, 24'd8380416, 24'd0, 24'd4096});
    end
    check_run_end("values", cyc);
  endtask

  task automatic test_full_wrap();
    int cyc;
    randomize_mem();
    start_run(14'h3FF0, 15'h7FF8);
    wait_done(cyc);
    check_run_end("wrap", cyc);
  endtask

  task automatic test_start_ignored();
    int cyc;
    randomize_mem();
    start_run(14'h1234, 15'h0400);
    repeat (50) @(negedge clk);
    src_base_i  = 14'h0777;
    dest_base_i = 15'h0777;
    start_i     = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    cyc = 52;
    while (!done_o && cyc < 2000) begin
      @(negedge clk);
      cyc++;
    end
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    repeat (10) @(negedge clk);
    check_run_end("busy_start", cyc);
  endtask

  task automatic test_zeroize();
    int cyc, rd0, wr0;
    randomize_mem();
    start_run(14'h0040, 15'h0200);
    cyc = 0;
    while (!(wr_count >= 29 && sk_rd_en_o) && cyc < 2000) begin
      @(negedge clk);
      cyc++;
    end
    n_checks++;
    if (cyc >= 2000) begin
      n_fail++;
      $display("FAIL zeroize_setup: got timeout want emission 30 with read in flight");
    end
    zeroize = 1'b1;
    @(negedge clk);
    zeroize = 1'b0;
    exp_q.delete();
    n_checks++;
    if ({busy_o, done_o, sk_rd_en_o, sk_rd_addr_o, mem_wr_en_o, mem_wr_addr_o, mem_wr_data_o} !== '0 || dut.fill !== 8'd0) begin
      n_fail++;
      $display("FAIL zeroize_outputs: got busy=%b rd=%b wr=%b fill=%0d want all 0", busy_o, sk_rd_en_o, mem_wr_en_o, dut.fill);
    end
    rd0 = rd_count;
    wr0 = wr_count;
    repeat (20) @(negedge clk);
    n_checks++;
    if (rd_count != rd0 || wr_count != wr0) begin
      n_fail++;
      $display("FAIL zeroize_quiet: got reads+%0d writes+%0d want 0 0", rd_count - rd0, wr_count - wr0);
    end
    start_run(14'h2000, 15'h1000);
    wait_done(cyc);
    check_run_end("after_zeroize", cyc);
  endtask

  initial begin
    test_reset();
    test_values();
    test_full_wrap();
    test_start_ignored();
    test_zeroize();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
